// File: rtl/param_updown_counter.sv
// Modulo-MOD up/down counter with wrap or saturate at the bounds, parallel load,
// cascade strobe (Tc) and a sticky boundary flag (Ovf). Registers update on the falling edge of Clk.
module param_updown_counter #(
  parameter int              WIDTH = 8,
  parameter longint unsigned MOD   = 256
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Count_en,
  input  logic             Up,
  input  logic             Sat_mode,
  input  logic             Clear_ovf,
  input  logic [WIDTH-1:0] Count_in,
  output logic [WIDTH-1:0] Count_out,
  output logic             Tc,
  output logic             Ovf,
  output logic             Zero
);

  // The top count value always fits in WIDTH bits, even when MOD == 2**WIDTH.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 64'd1);

  logic             at_max;
  logic             at_zero;
  logic             load_eff;
  logic             boundary;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;

  assign at_max   = (Count_out == MAXV);
  assign at_zero  = (Count_out == '0);
  assign load_eff = Load & ~Reset;
  assign boundary = Count_en & ~load_eff & (Up ? at_max : at_zero);

  assign Tc   = boundary;
  assign Zero = at_zero;

  always_comb begin
    count_nxt = Count_out;
    if (Load) begin
      count_nxt = (Count_in > MAXV) ? MAXV : Count_in;
    end else if (Count_en) begin
      if (Up) begin
        if (!at_max)
          count_nxt = Count_out + WIDTH'(1);
        else if (!Sat_mode)
          count_nxt = '0;
      end else begin
        if (!at_zero)
          count_nxt = Count_out - WIDTH'(1);
        else if (!Sat_mode)
          count_nxt = MAXV;
      end
    end
  end

  // A boundary event in the same cycle as Clear_ovf leaves the flag set.
  always_comb begin
    ovf_nxt = Ovf;
    if (boundary)
      ovf_nxt = 1'b1;
    else if (Clear_ovf)
      ovf_nxt = 1'b0;
  end

  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      Count_out <= '0;
      Ovf       <= 1'b0;
    end else begin
      Count_out <= count_nxt;
      Ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: directed boundary scenarios plus randomized traffic on a
// WIDTH=4/MOD=10 instance and a WIDTH=8/MOD=256 instance against an arithmetic model.
module tb_param_updown_counter;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       ld  [2];
   logic       en  [2];
   logic       up  [2];
   logic       sat [2];
   logic       clr [2];
   logic [7:0] cin [2];

   logic [3:0] a_cnt;
   logic [7:0] b_cnt;
   logic       a_tc, a_ovf, a_zero;
   logic       b_tc, b_ovf, b_zero;

   int unsigned mcnt  [2];
   bit          movf  [2];
   int unsigned mod_v [2] = '{10, 256};

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   param_updown_counter #(.WIDTH(4), .MOD(10)) dut_a (
      .Clk(Clk), .Reset(Reset), .Load(ld[0]), .Count_en(en[0]), .Up(up[0]),
      .Sat_mode(sat[0]), .Clear_ovf(clr[0]), .Count_in(cin[0][3:0]),
      .Count_out(a_cnt), .Tc(a_tc), .Ovf(a_ovf), .Zero(a_zero)
   );

   param_updown_counter #(.WIDTH(8), .MOD(256)) dut_b (
      .Clk(Clk), .Reset(Reset), .Load(ld[1]), .Count_en(en[1]), .Up(up[1]),
      .Sat_mode(sat[1]), .Clear_ovf(clr[1]), .Count_in(cin[1]),
      .Count_out(b_cnt), .Tc(b_tc), .Ovf(b_ovf), .Zero(b_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_bnd(input int i);
      return en[i] && !ld[i] && (up[i] ? (mcnt[i] == mod_v[i] - 1) : (mcnt[i] == 0));
   endfunction

   task automatic set_in(input int i, input bit l, input bit e, input bit u,
                         input bit s, input bit c, input logic [7:0] ci);
      ld[i] = l; en[i] = e; up[i] = u; sat[i] = s; clr[i] = c; cin[i] = ci;
   endtask

   task automatic check_comb();
      chk("a_tc",   a_tc,   m_bnd(0));
      chk("a_zero", a_zero, mcnt[0] == 0);
      chk("b_tc",   b_tc,   m_bnd(1));
      chk("b_zero", b_zero, mcnt[1] == 0);
   endtask

   task automatic check_regs();
      chk("a_cnt",  a_cnt,  mcnt[0]);
      chk("a_ovf",  a_ovf,  movf[0]);
      chk("a_zero", a_zero, mcnt[0] == 0);
      chk("b_cnt",  b_cnt,  mcnt[1]);
      chk("b_ovf",  b_ovf,  movf[1]);
      chk("b_zero", b_zero, mcnt[1] == 0);
   endtask

   // One falling edge: check strobes before it, advance the model, check registers after.
   task automatic cycle();
      bit          bnd [2];
      int unsigned m, c, ci;
      #1 check_comb();
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
         bnd[i] = m_bnd(i);
         m  = mod_v[i];
         c  = mcnt[i];
         ci = (i == 0) ? int'(cin[i][3:0]) : int'(cin[i]);
         if (ld[i])
            mcnt[i] = (ci < m) ? ci : m - 1;
         else if (en[i] && up[i])
            mcnt[i] = sat[i] ? ((c + 1 < m) ? c + 1 : m - 1) : (c + 1) % m;
         else if (en[i])
            mcnt[i] = sat[i] ? ((c == 0) ? 0 : c - 1) : (c + m - 1) % m;
         if (bnd[i])
            movf[i] = 1'b1;
         else if (clr[i])
            movf[i] = 1'b0;
      end
      #1 check_regs();
   endtask

   task automatic async_reset();
      #2 Reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         mcnt[i] = 0;
         movf[i] = 1'b0;
      end
      check_regs();
      chk("a_tc_rst", a_tc, en[0] && !up[0]);
      chk("b_tc_rst", b_tc, en[1] && !up[1]);
      #1 Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set_in(i, 0, 0, 0, 0, 0, 8'd0);
         mcnt[i] = 0;
         movf[i] = 1'b0;
      end
      #3;
      check_regs();
      check_comb();
      #3 Reset = 1'b0;
      @(negedge Clk);
      #1;

      // wrap-up on MOD=10
      set_in(0, 1, 0, 0, 0, 1, 8'd0); cycle();
      set_in(0, 0, 1, 1, 0, 0, 8'd0);
      repeat (12) cycle();
      chk("wrap_end", a_cnt, 2);
      chk("wrap_ovf", a_ovf, 1);

      // saturate-down from 2, then clear the flag
      set_in(0, 1, 0, 0, 1, 1, 8'd2); cycle();
      set_in(0, 0, 1, 0, 1, 0, 8'd0);
      repeat (4) cycle();
      chk("satdn_cnt", a_cnt, 0);
      chk("satdn_ovf", a_ovf, 1);
      set_in(0, 0, 0, 0, 1, 1, 8'd0); cycle();
      chk("satdn_clr", a_ovf, 0);

      // load clamp and load-over-count priority
      set_in(0, 1, 1, 1, 0, 0, 8'h0E); cycle();
      chk("clamp", a_cnt, 9);
      chk("clamp_ovf", a_ovf, 0);
      set_in(0, 1, 0, 0, 0, 0, 8'd3); cycle();
      chk("load3", a_cnt, 3);

      // set wins over clear
      set_in(0, 1, 0, 0, 0, 0, 8'd9); cycle();
      set_in(0, 0, 1, 1, 0, 1, 8'd0); cycle();
      chk("setclr_cnt", a_cnt, 0);
      chk("setclr_ovf", a_ovf, 1);

      // mid-cycle reset while counting at 7
      set_in(0, 1, 0, 0, 0, 0, 8'd6); cycle();
      set_in(0, 0, 1, 1, 0, 0, 8'd0); cycle();
      chk("pre_rst", a_cnt, 7);
      async_reset();
      chk("rst_cnt", a_cnt, 0);
      cycle();
      chk("post_rst", a_cnt, 1);

      // full range on MOD=256
      set_in(0, 0, 0, 0, 0, 0, 8'd0);
      set_in(1, 1, 0, 0, 0, 0, 8'd255); cycle();
      set_in(1, 0, 1, 1, 0, 0, 8'd0);
      #1 chk("full_tc", b_tc, 1);
      cycle();
      chk("full_up", b_cnt, 0);
      chk("full_ovf", b_ovf, 1);
      set_in(1, 0, 1, 0, 0, 0, 8'd0); cycle();
      chk("full_dn", b_cnt, 255);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < 2; i++)
            set_in(i, ($urandom % 8) == 0, ($urandom % 4) != 0, $urandom % 2,
                   $urandom % 2, ($urandom % 6) == 0,
                   (i == 0) ? 8'($urandom % 16) : 8'($urandom % 256));
         cycle();
         if (($urandom % 50) == 0)
            async_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
